// File: rtl/seg7_pkg.sv
// ----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment capture block:
//   seg7_t       : 7-bit active-high segment pattern, bit6=a ... bit0=g
//   cap_state_t  : capture FSM state encoding (IDLE / TRACK / LOCKED)
//   GLYPH_TABLE  : the 16 hex glyphs, indexed by hex value
//   CNT_W        : width of the stability counter (covers 1..15)
// ----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } cap_state_t;

    localparam int CNT_W       = 4;
    localparam int GLYPH_COUNT = 16;

    // Active-high segments a..g for 0..F (lower-case b and d glyphs).
    localparam seg7_t GLYPH_TABLE [GLYPH_COUNT] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011,  // 9
        7'b1110111,  // A
        7'b0011111,  // b
        7'b1001110,  // C
        7'b0111101,  // d
        7'b1001111,  // E
        7'b1000111   // F
    };

endpackage

// File: rtl/seg7_pattern_decode.sv
// ----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational lookup of an active-high segment pattern in the glyph table.
// Ports:
//   i_pattern : 7-bit active-high segment pattern (bit6=a ... bit0=g)
//   o_err     : 1 when the pattern is not one of the 16 hex glyphs
//   o_value   : matching hex value, 0 when o_err=1
// ----------------------------------------------------------------------------
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_pattern,
    output logic       o_err,
    output logic [3:0] o_value
);

    always_comb begin
        o_err   = 1'b1;
        o_value = 4'd0;
        for (int i = GLYPH_COUNT - 1; i >= 0; i--) begin
            if (i_pattern == GLYPH_TABLE[i]) begin
                o_err   = 1'b0;
                o_value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg7_decoder_capture.sv
// ----------------------------------------------------------------------------
// seg7_decoder_capture
// Watches a multiplexed, active-low seven-segment display bus, waits for a
// digit to be stable for STABLE_CYCLES consecutive samples, then commits it:
// the per-position digit store is updated and a valid/ready event is offered.
//
// Parameters:
//   NUM_DIGITS    : display positions monitored (2..8)
//   STABLE_CYCLES : identical consecutive samples needed to commit (1..15)
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   seg_n         : active-low segments, bit6=a ... bit0=g
//   sel_n         : active-low digit enables, one-hot low = valid scan slot
//   out_valid     : committed digit event pending
//   out_ready     : consumer accepts the event when high with out_valid
//   out_idx       : position of the event digit
//   out_value     : decoded hex value (0 on error)
//   out_err       : event pattern is not a hex glyph
//   digits        : last committed value per position, position 0 in LSBs
//   digit_vld     : position holds a valid committed value
//   overflow      : sticky, an event was dropped while out_valid was held
// Optional feature, macro SEG7_CAP_DP_EN:
//   dp_n          : active-low decimal point, part of the compared pattern
//   out_dp        : decimal point travelling with the event
// ----------------------------------------------------------------------------
module seg7_decoder_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
)
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [6:0]                seg_n,
    input  logic [NUM_DIGITS-1:0]     sel_n,
`ifdef SEG7_CAP_DP_EN
    input  logic                      dp_n,
    output logic                      out_dp,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2:0]                out_idx,
    output logic [3:0]                out_value,
    output logic                      out_err,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic [NUM_DIGITS-1:0]     digit_vld,
    output logic                      overflow
);

    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);

    // Input qualification (combinational)
    logic [NUM_DIGITS-1:0] w_sel;
    logic                  w_slot_ok;
    logic [2:0]            w_idx;
    seg7_t                 w_pat;
    logic                  w_dp;

    assign w_sel     = ~sel_n;
    assign w_pat     = ~seg_n;
    assign w_slot_ok = ($countones(w_sel) == 1) && (seg_n != 7'h7F);

`ifdef SEG7_CAP_DP_EN
    assign w_dp = ~dp_n;
`else
    assign w_dp = 1'b0;
`endif

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_sel[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    // ---- Stage p0: sample register, previous sample kept for comparison ----
    logic       r_smp_vld, r_prv_vld;
    logic [2:0] r_smp_idx, r_prv_idx;
    seg7_t      r_smp_pat, r_prv_pat;
    logic       r_smp_dp,  r_prv_dp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smp_vld <= 1'b0;
            r_smp_idx <= 3'd0;
            r_smp_pat <= '0;
            r_smp_dp  <= 1'b0;
            r_prv_vld <= 1'b0;
            r_prv_idx <= 3'd0;
            r_prv_pat <= '0;
            r_prv_dp  <= 1'b0;
        end else begin
            r_smp_vld <= w_slot_ok;
            r_smp_idx <= w_idx;
            r_smp_pat <= w_pat;
            r_smp_dp  <= w_dp;
            r_prv_vld <= r_smp_vld;
            r_prv_idx <= r_smp_idx;
            r_prv_pat <= r_smp_pat;
            r_prv_dp  <= r_smp_dp;
        end
    end

    logic w_same;
    assign w_same = r_prv_vld &&
                    ({r_smp_idx, r_smp_pat, r_smp_dp} == {r_prv_idx, r_prv_pat, r_prv_dp});

    // Decode the registered sample; this is the pattern a commit would carry.
    logic       w_dec_err;
    logic [3:0] w_dec_value;

    seg7_pattern_decode u_decode (
        .i_pattern (r_smp_pat),
        .o_err     (w_dec_err),
        .o_value   (w_dec_value)
    );

    // ---- Stage p1: stability FSM ----
    cap_state_t       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             w_commit, w_restart;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_commit    = 1'b0;
        w_restart   = 1'b0;

        if (!r_smp_vld) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_restart = 1'b1;
                ST_TRACK: begin
                    if (w_same) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == STABLE_C) begin
                            w_commit    = 1'b1;
                            w_state_nxt = ST_LOCKED;
                        end
                    end else begin
                        w_restart = 1'b1;
                    end
                end
                // Already committed this pattern: hold until it changes.
                ST_LOCKED: w_restart = !w_same;
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // A fresh valid pattern counts as its first sample; with a
        // single-sample threshold it commits straight away.
        if (w_restart) begin
            w_cnt_nxt = CNT_W'(1);
            if (STABLE_C == CNT_W'(1)) begin
                w_commit    = 1'b1;
                w_state_nxt = ST_LOCKED;
            end else begin
                w_state_nxt = ST_TRACK;
            end
        end
    end

    // ---- Stage p2: digit store and event output register ----
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_digit_vld;
    logic                    r_out_valid, r_out_err, r_overflow;
    logic [2:0]              r_out_idx;
    logic [3:0]              r_out_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits    <= '0;
            r_digit_vld <= '0;
        end else if (w_commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (3'(i) == r_smp_idx) begin
                    // An error glyph invalidates the position but keeps
                    // the last good value.
                    if (w_dec_err) begin
                        r_digit_vld[i] <= 1'b0;
                    end else begin
                        r_digits[i*4 +: 4] <= w_dec_value;
                        r_digit_vld[i]     <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef SEG7_CAP_DP_EN
    logic r_out_dp;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_idx   <= 3'd0;
            r_out_value <= 4'd0;
            r_out_err   <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef SEG7_CAP_DP_EN
            r_out_dp    <= 1'b0;
`endif
        end else if (w_commit) begin
            // Load when the slot is free or being accepted this cycle
            // (no bubble); otherwise the new event is lost.
            if (!r_out_valid || out_ready) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= r_smp_idx;
                r_out_value <= w_dec_err ? 4'd0 : w_dec_value;
                r_out_err   <= w_dec_err;
`ifdef SEG7_CAP_DP_EN
                r_out_dp    <= r_smp_dp;
`endif
            end else begin
                r_overflow <= 1'b1;
            end
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_idx   = r_out_idx;
    assign out_value = r_out_value;
    assign out_err   = r_out_err;
    assign digits    = r_digits;
    assign digit_vld = r_digit_vld;
    assign overflow  = r_overflow;
`ifdef SEG7_CAP_DP_EN
    assign out_dp    = r_out_dp;
`endif

endmodule

// File: tb/tb_seg7_decoder_capture.sv
// ----------------------------------------------------------------------------
// tb_seg7_decoder_capture
// Directed bench for seg7_decoder_capture (NUM_DIGITS=4, STABLE_CYCLES=3).
// Accepted events are logged by a monitor; each scenario task compares
// outputs and the log against hand-computed values.
// The decimal-point scenario is built only when SEG7_CAP_DP_EN is defined.
// ----------------------------------------------------------------------------
module tb_seg7_decoder_capture;

    localparam int ND = 4;

    typedef struct packed {
        logic [2:0] idx;
        logic [3:0] val;
        logic       err;
        logic       dp;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [6:0]      seg_n;
    logic [ND-1:0]   sel_n;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      out_idx;
    logic [3:0]      out_value;
    logic            out_err;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   digit_vld;
    logic            overflow;
    logic            dp_out;
`ifdef SEG7_CAP_DP_EN
    logic            dp_n;
    logic            out_dp;
    assign dp_out = out_dp;
`else
    assign dp_out = 1'b0;
`endif

    int  checks   = 0;
    int  failures = 0;
    ev_t evq[$];
    ev_t exp_ev;

    always #5 clk = ~clk;

    seg7_decoder_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg_n     (seg_n),
        .sel_n     (sel_n),
`ifdef SEG7_CAP_DP_EN
        .dp_n      (dp_n),
        .out_dp    (out_dp),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_value (out_value),
        .out_err   (out_err),
        .digits    (digits),
        .digit_vld (digit_vld),
        .overflow  (overflow)
    );

    // Event log: one entry per accepted handshake.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            evq.push_back('{idx: out_idx, val: out_value, err: out_err, dp: dp_out});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg);
        sel_n = sel;
        seg_n = seg;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(2);
        checks++;
        if ({out_valid, out_idx, out_value, out_err, overflow} !== 10'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {out_valid, out_idx, out_value, out_err, overflow});
        end
        checks++;
        if ({digits, digit_vld} !== 20'd0) begin
            failures++;
            $display("FAIL reset_digits: got %h expected 0", {digits, digit_vld});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_commit_zero;
        evq.delete();
        drive(4'b1110, 7'b0000001);
        tick(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_early: out_valid=%b expected 0", out_valid);
        end
        drive(4'b1111, 7'b1111111);
        tick(1);
        checks++;
        if ({out_valid, out_idx, out_value, out_err} !== {1'b1, 3'd0, 4'd0, 1'b0}) begin
            failures++;
            $display("FAIL zero_event: got v%b i%0d x%0h e%b expected v1 i0 x0 e0",
                     out_valid, out_idx, out_value, out_err);
        end
        checks++;
        if (digit_vld !== 4'b0001) begin
            failures++;
            $display("FAIL zero_vld: got %b expected 0001", digit_vld);
        end
        tick(1);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL zero_drop: out_valid=%b expected 0", out_valid);
        end
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL zero_count: got %0d events expected 1", evq.size());
        end
    endtask

    task automatic test_restart;
        evq.delete();
        drive(4'b1011, 7'b0001000);
        tick(2);
        drive(4'b1011, 7'b1001111);
        tick(3);
        drive(4'b1111, 7'b1111111);
        tick(1);
        checks++;
        if ({out_valid, out_idx, out_value, out_err} !== {1'b1, 3'd2, 4'd1, 1'b0}) begin
            failures++;
            $display("FAIL restart_event: got v%b i%0d x%0h e%b expected v1 i2 x1 e0",
                     out_valid, out_idx, out_value, out_err);
        end
        tick(3);
        exp_ev = '{idx: 3'd2, val: 4'd1, err: 1'b0, dp: 1'b0};
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL restart_count: got %0d events expected 1", evq.size());
        end else if (evq[0] !== exp_ev) begin
            failures++;
            $display("FAIL restart_log: got %h expected %h", evq[0], exp_ev);
        end
        checks++;
        if ({digits, digit_vld} !== {16'h0100, 4'b0101}) begin
            failures++;
            $display("FAIL restart_store: got %h/%b expected 0100/0101", digits, digit_vld);
        end
    endtask

    task automatic test_err;
        evq.delete();
        drive(4'b0111, 7'b0101010);
        tick(3);
        drive(4'b1111, 7'b1111111);
        tick(1);
        checks++;
        if ({out_valid, out_idx, out_value, out_err} !== {1'b1, 3'd3, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL err_event: got v%b i%0d x%0h e%b expected v1 i3 x0 e1",
                     out_valid, out_idx, out_value, out_err);
        end
        tick(3);
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL err_count: got %0d events expected 1", evq.size());
        end
        checks++;
        if ({digits, digit_vld} !== {16'h0100, 4'b0101}) begin
            failures++;
            $display("FAIL err_store: got %h/%b expected 0100/0101", digits, digit_vld);
        end
    endtask

    task automatic test_overflow;
        evq.delete();
        out_ready = 1'b0;
        drive(4'b1110, 7'b0010010);
        tick(3);
        drive(4'b1101, 7'b1001111);
        tick(3);
        drive(4'b1111, 7'b1111111);
        tick(4);
        checks++;
        if ({out_valid, out_idx, out_value, out_err} !== {1'b1, 3'd0, 4'd2, 1'b0}) begin
            failures++;
            $display("FAIL ovf_held: got v%b i%0d x%0h e%b expected v1 i0 x2 e0",
                     out_valid, out_idx, out_value, out_err);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_flag: got %b expected 1", overflow);
        end
        checks++;
        if ({digits, digit_vld} !== {16'h0112, 4'b0111}) begin
            failures++;
            $display("FAIL ovf_store: got %h/%b expected 0112/0111", digits, digit_vld);
        end
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL ovf_noaccept: got %0d events expected 0", evq.size());
        end
        out_ready = 1'b1;
        tick(1);
        exp_ev = '{idx: 3'd0, val: 4'd2, err: 1'b0, dp: 1'b0};
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL ovf_count: got %0d events expected 1", evq.size());
        end else if (evq[0] !== exp_ev) begin
            failures++;
            $display("FAIL ovf_log: got %h expected %h", evq[0], exp_ev);
        end
        checks++;
        if ({out_valid, overflow} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_after: got v%b o%b expected v0 o1", out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back;
        evq.delete();
        out_ready = 1'b0;
        drive(4'b1101, 7'b0000110);
        tick(3);
        drive(4'b1011, 7'b1001100);
        tick(3);
        drive(4'b1111, 7'b1111111);
        out_ready = 1'b1;
        tick(1);
        checks++;
        if ({out_valid, out_idx, out_value} !== {1'b1, 3'd2, 4'd4}) begin
            failures++;
            $display("FAIL b2b_load: got v%b i%0d x%0h expected v1 i2 x4",
                     out_valid, out_idx, out_value);
        end
        exp_ev = '{idx: 3'd1, val: 4'd3, err: 1'b0, dp: 1'b0};
        checks++;
        if (evq.size() != 1) begin
            failures++;
            $display("FAIL b2b_first_count: got %0d events expected 1", evq.size());
        end else if (evq[0] !== exp_ev) begin
            failures++;
            $display("FAIL b2b_first: got %h expected %h", evq[0], exp_ev);
        end
        tick(1);
        exp_ev = '{idx: 3'd2, val: 4'd4, err: 1'b0, dp: 1'b0};
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL b2b_second_count: got %0d events expected 2", evq.size());
        end else if (evq[1] !== exp_ev) begin
            failures++;
            $display("FAIL b2b_second: got %h expected %h", evq[1], exp_ev);
        end
        checks++;
        if ({out_valid, digits, digit_vld} !== {1'b0, 16'h0432, 4'b0111}) begin
            failures++;
            $display("FAIL b2b_store: got v%b %h/%b expected v0 0432/0111",
                     out_valid, digits, digit_vld);
        end
    endtask

    task automatic test_invalid_and_reset;
        evq.delete();
        drive(4'b1100, 7'b0000001);
        tick(10);
        drive(4'b1110, 7'b1111111);
        tick(10);
        drive(4'b1111, 7'b0000001);
        tick(5);
        checks++;
        if (evq.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_noevent: got %0d events v%b expected 0 v0",
                     evq.size(), out_valid);
        end
        checks++;
        if (digits !== 16'h0432) begin
            failures++;
            $display("FAIL invalid_store: got %h expected 0432", digits);
        end
        // Reset while tracking digit 5 on position 1
        drive(4'b1101, 7'b0100100);
        tick(2);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_idx, out_value, out_err, overflow, digits, digit_vld} !== 30'd0) begin
            failures++;
            $display("FAIL midreset: got %h expected 0",
                     {out_valid, out_idx, out_value, out_err, overflow, digits, digit_vld});
        end
        tick(1);
        rst_n = 1'b1;
        tick(3);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL postreset_early: out_valid=%b expected 0", out_valid);
        end
        tick(1);
        checks++;
        if ({out_valid, out_idx, out_value, out_err} !== {1'b1, 3'd1, 4'd5, 1'b0}) begin
            failures++;
            $display("FAIL postreset_event: got v%b i%0d x%0h e%b expected v1 i1 x5 e0",
                     out_valid, out_idx, out_value, out_err);
        end
        drive(4'b1111, 7'b1111111);
        tick(2);
    endtask

`ifdef SEG7_CAP_DP_EN
    task automatic test_dp;
        evq.delete();
        dp_n = 1'b1;
        drive(4'b1110, 7'b0000001);
        tick(4);
        dp_n = 1'b0;
        tick(3);
        tick(1);
        checks++;
        if ({out_valid, out_idx, out_value, out_dp} !== {1'b1, 3'd0, 4'd0, 1'b1}) begin
            failures++;
            $display("FAIL dp_event: got v%b i%0d x%0h d%b expected v1 i0 x0 d1",
                     out_valid, out_idx, out_value, out_dp);
        end
        drive(4'b1111, 7'b1111111);
        tick(2);
        checks++;
        if (evq.size() != 2) begin
            failures++;
            $display("FAIL dp_count: got %0d events expected 2", evq.size());
        end else if (evq[0].dp !== 1'b0 || evq[1].dp !== 1'b1) begin
            failures++;
            $display("FAIL dp_log: got %b%b expected 01", evq[0].dp, evq[1].dp);
        end
        dp_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n     = 1'b0;
        sel_n     = '1;
        seg_n     = 7'b1111111;
        out_ready = 1'b1;
`ifdef SEG7_CAP_DP_EN
        dp_n      = 1'b1;
`endif
        test_reset();
        test_commit_zero();
        test_restart();
        test_err();
        test_overflow();
        test_back_to_back();
        test_invalid_and_reset();
`ifdef SEG7_CAP_DP_EN
        test_dp();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_decoder_capture.md
SEG7_DECODER_CAPTURE -- requirements
Module: seg7_decoder_capture

Interface
REQ-001 Parameter NUM_DIGITS, 4, number of multiplexed display positions monitored (2..8).
REQ-002 Parameter STABLE_CYCLES, 3, consecutive identical samples required to commit a digit (1..15).
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port seg_n  input  7  active-low segments, bit6=a ... bit0=g.
REQ-006 Port sel_n  input  NUM_DIGITS  active-low digit enables; exactly one low means a valid scan slot.
REQ-007 Port out_valid  output  1  committed digit event pending.
REQ-008 Port out_ready  input  1  consumer accepts the event when high together with out_valid.
REQ-009 Port out_idx  output  3  position of the event digit.
REQ-010 Port out_value  output  4  decoded hex value; 0 when out_err=1.
REQ-011 Port out_err  output  1  event pattern is not one of the 16 hex glyphs.
REQ-012 Port digits  output  4*NUM_DIGITS  last committed value per position, position 0 in LSBs.
REQ-013 Port digit_vld  output  NUM_DIGITS  position has a valid (non-error) committed value.
REQ-014 Port overflow  output  1  sticky: an event was dropped because out_valid was held.

Function
REQ-015 Decode: inverted seg_n matched against the shared 16-entry glyph table (0=1111110 ... F=1000111); no match -> err.
REQ-016 Sample each cycle into a register; compare {idx, pattern} with the previous sample.
REQ-017 FSM states IDLE, TRACK, LOCKED.
REQ-018 IDLE: zero or multiple sel_n low, or seg_n all ones (blank); counter cleared; a valid slot moves to TRACK with count=1.
REQ-019 TRACK: same {idx, pattern} increments count; at count==STABLE_CYCLES commit and go LOCKED; any change restarts TRACK with count=1 (or goes IDLE if the slot is invalid/blank).
REQ-020 LOCKED: no further commit while {idx, pattern} unchanged; a change behaves as in TRACK/IDLE.
REQ-021 Commit latency: event visible on out_valid the cycle after the STABLE_CYCLES-th identical sample is registered.
REQ-022 Commit writes digits/digit_vld for that idx (err clears digit_vld, leaves digits unchanged) and loads the output register.
REQ-023 Handshake: out_valid stays high, with out_idx/out_value/out_err stable, until out_valid&&out_ready; then it drops next cycle unless a new commit occurs in the same cycle, which is loaded instead (no bubble).
REQ-024 Commit while out_valid high and out_ready low: event dropped from the stream, digits still updated, overflow set.
REQ-025 Commit index wraps nothing; idx >= NUM_DIGITS cannot occur because sel_n is one-hot checked.

Reset
REQ-026 rst_n low asynchronously forces IDLE, count 0, out_valid 0, out_idx/out_value/out_err 0, digits 0, digit_vld 0, overflow 0.
REQ-027 Reset mid-TRACK or with out_valid pending discards all progress; first post-reset commit needs a full STABLE_CYCLES.

Configuration
REQ-028 Macro SEG7_CAP_DP_EN defined: extra input dp_n (1, active-low decimal point) and output out_dp (1); dp is part of the compared pattern and travels with the event.
REQ-029 Macro undefined: no dp_n/out_dp ports; behaviour identical otherwise.

Structure
REQ-030 Package seg7_pkg holds the 16-entry glyph constant table, the FSM state enum and the 7-bit segment type.
REQ-031 Sub-module seg7_pattern_decode: combinational 7-bit pattern -> {err, value}, instanced once.

Verification
REQ-032 sel_n=4'b1110, seg_n=7'b0000001 for 3 cycles -> one event idx=0 value=0 err=0; digit_vld[0]=1.
REQ-033 sel_n=4'b1011, seg_n=7'b0001000 for 2 cycles then 7'b1001111 for 3 -> single event idx=2 value=1, no event for A.
REQ-034 sel_n=4'b0111, seg_n=7'b0101010 for 3 cycles -> event idx=3 err=1 value=0; digit_vld[3]=0.
REQ-035 out_ready=0, commit digit 2 (seg_n=7'b0010010) on idx0 then digit 1 on idx1 -> first event held, overflow=1, digits[7:4]=1.
REQ-036 sel_n=4'b1100 or seg_n=7'b1111111 for 10 cycles -> no event; rst_n pulsed low mid-TRACK -> all outputs 0 immediately.
REQ-037 With SEG7_CAP_DP_EN: same glyph, dp_n toggled after commit, held 3 cycles -> second event with out_dp=1.
